// File: rtl/data_mem_responder.sv
// Single-outstanding request/response data memory with programmable access latency.
// Out-of-range word addresses return an error and never touch the array.
module data_mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  state_t      state, state_nx;
  logic [3:0]  lat_cnt;
  logic        op_write;
  logic [15:0] op_addr;
  logic [15:0] op_wdata;
  logic [15:0] rdata_q;
  logic        err_q;
  logic        accept;
  logic        access;
  logic        in_range;

  logic [15:0] mem [2**ADDR_BITS];

  assign accept   = (state == IDLE) && req_valid;
  assign access   = (state == WAIT) && (lat_cnt == 4'd0);
  assign in_range = ((op_addr >> ADDR_BITS) == 16'd0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid)  state_nx = WAIT;
      WAIT:    if (access)     state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    resp_rdata = (state == RESP) ? rdata_q : 16'h0000;
    resp_err   = (state == RESP) ? err_q : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_cnt  <= 4'd0;
      op_write <= 1'b0;
      op_addr  <= 16'h0000;
      op_wdata <= 16'h0000;
      rdata_q  <= 16'h0000;
      err_q    <= 1'b0;
      rd_count <= 16'h0000;
      wr_count <= 16'h0000;
    end else begin
      if (accept) begin
        op_write <= req_write;
        op_addr  <= req_addr;
        op_wdata <= req_wdata;
        lat_cnt  <= LAT_INIT;
      end else if ((state == WAIT) && (lat_cnt != 4'd0)) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      if (access) begin
        err_q <= ~in_range;
        if (!in_range)     rdata_q <= 16'h0000;
        else if (op_write) rdata_q <= op_wdata;
        else               rdata_q <= mem[op_addr[ADDR_BITS-1:0]];
        // errored accesses still count as completed operations
        if (op_write) begin
          if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end else begin
          if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
        end
      end
    end
  end

  // array is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (!reset && access && op_write && in_range)
      mem[op_addr[ADDR_BITS-1:0]] <= op_wdata;
  end

endmodule
